// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and defaults, used by the alu and its arbiter.
package alu_pkg;

    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd4;

    // Opcode driven onto the alu when nobody holds a grant.
    localparam logic [ALU_OP_W-1:0] ALU_IDLE_OP = ALU_PASS;

    // Which requester owns the alu in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// One-entry response buffer: captures an alu result/zero/tag on push and
// holds it until the consumer pops. Pop and push may coincide.
module alu_rsp_slot
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic             zero_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic             free_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [TAG_W-1:0] tag_q;

    // A pop frees the slot in the same cycle so it can be refilled immediately.
    assign free_o = !valid_q || pop_i;

    // Occupancy next state: a push always wins over a pop.
    always_comb begin
        valid_d = valid_q;
        if (push_i) begin
            valid_d = 1'b1;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers only change on a push; a bare pop leaves them as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            tag_q    <= '0;
        end else if (push_i) begin
            result_q <= result_i;
            zero_q   <= zero_i;
            tag_q    <= tag_i;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational alu between the execute stage (port 0,
// fixed priority) and the speculative evaluator (port 1, aged so it never
// starves). Results are captured straight from the alu into per-port slots.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = ALU_WIDTH,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    // port 0 request
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [TAG_W-1:0]    req0_tag,
    // port 1 request
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [TAG_W-1:0]    req1_tag,
    // port 0 response
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WIDTH-1:0]    rsp0_result,
    output logic                rsp0_zero,
    output logic [TAG_W-1:0]    rsp0_tag,
    // port 1 response
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WIDTH-1:0]    rsp1_result,
    output logic                rsp1_zero,
    output logic [TAG_W-1:0]    rsp1_tag,
    // external alu
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [WIDTH-1:0]    alu_op_a,
    output logic [WIDTH-1:0]    alu_op_b,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_zero,
    // debug
    output logic [1:0]          wait1_cnt
);

    localparam logic [1:0] WAIT_MAX = 2'(MAX_WAIT);

    logic       free0, free1;
    logic       elig0, elig1;
    logic       grant0, grant1;
    gnt_e       gnt;
    logic [1:0] wait1_q, wait1_d;

    assign elig0 = req0_valid && free0;
    assign elig1 = req1_valid && free1;

    // Grant select: aged port 1 first, then port 0, then port 1; nothing in reset.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (elig1 && (wait1_q == WAIT_MAX)) begin
                gnt = GNT_P1;
            end else if (elig0) begin
                gnt = GNT_P0;
            end else if (elig1) begin
                gnt = GNT_P1;
            end
        end
    end

    assign grant0     = (gnt == GNT_P0);
    assign grant1     = (gnt == GNT_P1);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand/opcode mux onto the shared alu; idle drives PASS of zero.
    always_comb begin
        alu_op   = ALU_IDLE_OP;
        alu_op_a = '0;
        alu_op_b = '0;
        case (gnt)
            GNT_P0: begin
                alu_op   = req0_op;
                alu_op_a = req0_a;
                alu_op_b = req0_b;
            end
            GNT_P1: begin
                alu_op   = req1_op;
                alu_op_a = req1_a;
                alu_op_b = req1_b;
            end
            default: begin
                alu_op   = ALU_IDLE_OP;
                alu_op_a = '0;
                alu_op_b = '0;
            end
        endcase
    end

    // Port 1 aging: count only real arbitration losses; stalls on its own
    // full response slot leave the count unchanged.
    always_comb begin
        wait1_d = wait1_q;
        if (!req1_valid || grant1) begin
            wait1_d = '0;
        end else if (elig1) begin
            wait1_d = (wait1_q == WAIT_MAX) ? wait1_q : wait1_q + 2'd1;
        end
    end

    // Aging counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait1_q <= '0;
        end else begin
            wait1_q <= wait1_d;
        end
    end

    assign wait1_cnt = wait1_q;

    alu_rsp_slot #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .push_i   (grant0),
        .pop_i    (rsp0_ready),
        .result_i (alu_result),
        .zero_i   (alu_zero),
        .tag_i    (req0_tag),
        .valid_o  (rsp0_valid),
        .free_o   (free0),
        .result_o (rsp0_result),
        .zero_o   (rsp0_zero),
        .tag_o    (rsp0_tag)
    );

    alu_rsp_slot #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .push_i   (grant1),
        .pop_i    (rsp1_ready),
        .result_i (alu_result),
        .zero_i   (alu_zero),
        .tag_i    (req1_tag),
        .valid_o  (rsp1_valid),
        .free_o   (free1),
        .result_o (rsp1_result),
        .zero_o   (rsp1_zero),
        .tag_o    (rsp1_tag)
    );

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: port 0 is the main pipeline execute stage, port 1 is the slot-fill scheduler's speculative evaluator. Each port has a valid/ready request channel and a one-entry registered response buffer. Port 0 has fixed priority, and an aging counter guarantees that port 1 is never starved. The block drives the external `alu` instance's operand and opcode inputs and captures its `result` and `zero` outputs.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `TAG_W`, 4: opaque request tag width, returned unchanged with the result.
- `MAX_WAIT`, 3: number of consecutive lost arbitrations after which port 1 wins.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_op` in 4: ALU opcode (ADD=0, SUB=1, AND=2, OR=3, PASS=4).
- `reqN_a`, `reqN_b` in WIDTH: operands.
- `reqN_tag` in TAG_W: requester tag.
- `rspN_valid` out 1: response buffer full.
- `rspN_ready` in 1: consumer pops the response.
- `rspN_result` out WIDTH: captured ALU result.
- `rspN_zero` out 1: captured ALU zero flag.
- `rspN_tag` out TAG_W: tag of the captured request.
- `alu_op` out 4: drives the alu opcode input.
- `alu_op_a`, `alu_op_b` out WIDTH: drive the alu operand inputs.
- `alu_result` in WIDTH: alu result.
- `alu_zero` in 1: alu zero flag.
- `wait1_cnt` out 2: port 1 aging counter, visible for debug.

## Operation
- slot_freeN = !rspN_valid | rspN_ready. A port may pop its buffer and refill it in the same cycle.
- eligibleN = reqN_valid & slot_freeN.
- Grant logic is combinational:
  - If eligible1 & (wait1_cnt == MAX_WAIT): grant port 1.
  - Else if eligible0: grant port 0.
  - Else if eligible1: grant port 1.
  - Else: no grant.
- reqN_ready = grantN. It never depends on the other port's valid except through priority.
- ALU mux:
  - With a grant, `alu_op`/`alu_op_a`/`alu_op_b` take the granted port's op/a/b.
  - With no grant, they drive op=4 (PASS) with both operands 0.
- On an edge with grantN:
  - rspN_result ← alu_result, rspN_zero ← alu_zero, rspN_tag ← reqN_tag.
  - rspN_valid ← 1.
- On an edge with rspN_ready & rspN_valid & !grantN: rspN_valid ← 0. The data registers hold their values.
- Aging counter wait1_cnt:
  - Cleared when port 1 is granted or when req1_valid = 0.
  - Incremented, saturating at MAX_WAIT, when eligible1 & !grant1.
  - Held when req1_valid & !slot_free1, because losing to its own back-pressure does not count as losing arbitration.
- Undefined opcodes pass through unchanged. The response carries whatever the alu returns (0xDEADBEEF, zero=0).

## Timing
- Reset values: rspN_valid=0, rspN_result=0, rspN_zero=0, rspN_tag=0, wait1_cnt=0.
- Reset is asynchronous: asserting rst mid-operation discards buffered responses immediately.
- `alu_*` outputs and reqN_ready are combinational, so they are 0/PASS during reset.
- Latency: a request accepted at edge k has rspN_valid=1 in the cycle after edge k.
- Throughput: one grant per cycle in total. A single port sustains 1 op/cycle when its consumer holds rspN_ready=1.
- Handshake rules:
  - Requester holds reqN_* stable while reqN_valid=1 and reqN_ready=0.
  - Response fields are stable while rspN_valid=1 and rspN_ready=0.
- Worst-case port 1 wait under continuous port 0 traffic is MAX_WAIT cycles. Grant occurs in cycle MAX_WAIT+1.
- Combinational path: req inputs → grant → alu → response registers. There is no register between the ALU and the capture.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams ALU_ADD/SUB/AND/OR/PASS.
  - ALU_IDLE_OP (= PASS).
  - Default WIDTH.
  - Used by both `alu` and this block.
- Sub-module `alu_rsp_slot`:
  - One-entry result/zero/tag buffer with push/pop/valid and a `free` output.
  - Instantiated twice.
- The `alu` instance lives outside this block, in the execute-stage top.

## Test plan
- Reset then idle, no requests → alu_op=4, alu_op_a=alu_op_b=0, both rsp_valid=0, wait1_cnt=0.
- Port 0 only: ADD 5+7 tag 3 → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, result=12, zero=0, tag=3.
- Both valid every cycle, rsp*_ready=1, MAX_WAIT=3 → grant pattern 0,0,0,1 repeating; wait1_cnt sequence 0,1,2,3,0.
- Port 0 SUB 9-9 with rsp0_ready=0 → rsp0_zero=1 is held; a second port 0 request sees req0_ready=0 and port 1 is granted instead. Raising rsp0_ready pops and refills in the same cycle.
- Undefined opcode 4'hF on port 1 → rsp1_result=0xDEADBEEF, rsp1_zero=0.
- rst asserted while rsp1_valid=1 → rsp1_valid=0 immediately, without waiting for an edge; wait1_cnt=0.
